peg_mac_pipe: RTL
=================

Name: peg_mac_pipe

Overview:
- Multi-lane, parametrised, pipelined signed-by-(un)signed multiply/accumulate engine for the Sextans PE group (PEG) datapath.
- Generalises the fixed 16s x 14ns four-stage multiplier with:
  - configurable widths, lane count and latency;
  - selectable B signedness;
  - valid/ready flow control;
  - per-lane saturating accumulation over beat groups.
- Sits between the B-matrix/A-value streams and the C-row writeback inside a PEG.

Parameters:
- LANES, 4, number of independent multiply lanes sharing one handshake.
- A_WIDTH, 16, width of each signed A operand.
- B_WIDTH, 14, width of each B operand.
- B_SIGNED, 0, 0: B is zero-extended (unsigned); 1: B is two's complement.
- MUL_STAGES, 3, product pipeline depth including the input register; must be >= 1.
- ACC_WIDTH, 40, per-lane result/accumulator width; must be >= A_WIDTH+B_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_a  input  LANES*A_WIDTH  lane i A operand at bits [i*A_WIDTH +: A_WIDTH].
- in_b  input  LANES*B_WIDTH  lane i B operand, same packing.
- in_acc  input  1  1: beat joins the open accumulation group; 0: standalone product.
- in_last  input  1  with in_acc=1, closes the group and emits its result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  LANES*ACC_WIDTH  lane i result, sign-extended or saturated.
- out_sat  output  LANES  lane i saturated at least once during the emitted result.

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - Reset is synchronous and active-low on reset_n.
  - While reset_n=0 at a rising edge, the following are cleared to 0: all pipeline valid bits, out_valid, out_data, out_sat, every lane accumulator, the sat flags, and the group-open flag.
  - in_ready is forced 0 while reset_n=0.
  - Reset mid-group discards the partial sum; the first beat after reset starts a fresh group.
- Arithmetic:
  - Product P = signed(A) * B'. PROD_W = A_WIDTH+B_WIDTH.
  - B' is signed(B) when B_SIGNED=1, and signed({1'b0,B}) when B_SIGNED=0.
  - P is exact in PROD_W bits and is sign-extended to ACC_WIDTH+1 for summation.
- Pipeline:
  - MUL_STAGES product stages followed by one accumulate/output register.
  - With no stall, a beat accepted at edge k produces out_valid at edge k+MUL_STAGES+1. Defaults give 4 cycles, matching the legacy multiplier.
  - in_acc and in_last travel in lockstep with the operands.
- Flow control:
  - Global advance enable en = !out_valid || out_ready; in_ready = en (when not in reset).
  - When en=0, every stage and the output register hold; no beat is lost or duplicated.
  - out_valid && out_ready together with a new result arriving at the output stage: the output reloads in the same cycle, with no bubble.
  - Results leave in acceptance order.
- Accumulate stage, per beat reaching it:
  - in_acc=0:
    - Emit sat(P).
    - Accumulators, sat flags and group-open flag are untouched, even while a group is open.
    - out_sat = 0.
  - in_acc=1:
    - base = group_open ? acc : 0; sum = base + P, saturated to the signed ACC_WIDTH range.
    - last=0: acc <= sum; the sticky sat flag is ORed with this beat's saturation; group_open <= 1; no output.
    - last=1: emit sum with out_sat = sticky | this beat's saturation; then acc, sat and group_open are cleared.
  - Saturation clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1). The accumulator then continues from the clamped value.
  - A group of one beat (acc=1, last=1, no group open) emits P.
- Output:
  - out_data and out_sat change only when a result loads into the output register.
  - Both are held stable while out_valid && !out_ready.

Test Plan:
- Multiply-only, defaults: lane0 a=-3, b=5; lane1 a=32767, b=16383; in_acc=0 -> out_valid 4 cycles after acceptance; lane0=-15, lane1=536821761, out_sat=0.
- Signedness: a=2, b=0x3FFF -> 32766 with B_SIGNED=0; -2 with B_SIGNED=1.
- Accumulate: 3 beats, lane0 a=100, b=200, in_acc=1, last only on the 3rd -> exactly one output, lane0=60000, and no out_valid for beats 1-2.
- Backpressure: back-to-back stream of 8 beats (a=i, b=1) with out_ready low for 5 cycles mid-stream -> in_ready low while stalled, out_data held; outputs 0..7 in order, none lost or duplicated.
- Saturation, ACC_WIDTH=30: 3 accumulate beats of a=-32768, b=16383, last on the 3rd -> lane0=-536870912, out_sat[0]=1; next group of a=1, b=1 -> 1 with out_sat=0.
- Reset mid-group: 2 accumulate beats (a=5, b=5), reset_n low 1 cycle, then single beat a=1, b=1, acc=1, last=1 -> output 1; all outputs 0 during reset.

Source files
------------

// File: rtl/peg_mac_pipe.sv
// peg_mac_pipe: multi-lane pipelined signed multiply / saturating accumulate
// engine for the PEG datapath. One valid/ready handshake drives all lanes. An
// operand register and MUL_STAGES product registers feed a shared
// accumulate/output register. With no stall a result appears MUL_STAGES+1
// edges after its beat is accepted.
module peg_mac_pipe #(
    parameter int LANES      = 4,
    parameter int A_WIDTH    = 16,
    parameter int B_WIDTH    = 14,
    parameter int B_SIGNED   = 0,
    parameter int MUL_STAGES = 3,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*A_WIDTH-1:0]     in_a,
    input  logic [LANES*B_WIDTH-1:0]     in_b,
    input  logic                         in_acc,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]             out_sat
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Global advance enable: the whole pipe moves only when the output slot frees up.
    logic                               w_en;

    // Operand register
    logic                               r_in_valid;
    logic                               r_in_acc;
    logic                               r_in_last;
    logic [LANES*A_WIDTH-1:0]           r_in_a;
    logic [LANES*B_WIDTH-1:0]           r_in_b;

    // Product pipeline; products are kept at ACC_WIDTH because the exact
    // A_WIDTH+B_WIDTH product always fits there.
    logic [LANES-1:0][ACC_WIDTH-1:0]    w_prod;
    logic [LANES-1:0][ACC_WIDTH-1:0]    r_p_data [MUL_STAGES];
    logic [MUL_STAGES-1:0]              r_p_valid;
    logic [MUL_STAGES-1:0]              r_p_acc;
    logic [MUL_STAGES-1:0]              r_p_last;

    // Beat arriving at the accumulate stage
    logic [LANES-1:0][ACC_WIDTH-1:0]    w_t_prod;
    logic                               w_t_valid;
    logic                               w_t_acc;
    logic                               w_t_last;

    // Accumulator state and per-lane saturated sums
    logic [LANES-1:0][ACC_WIDTH-1:0]    r_acc;
    logic [LANES-1:0][ACC_WIDTH-1:0]    w_sum_sat;
    logic [LANES-1:0]                   w_ovf;
    logic [LANES-1:0]                   r_sat;
    logic                               r_group_open;

    // Output register
    logic                               r_out_valid;
    logic [LANES-1:0][ACC_WIDTH-1:0]    r_out_data;
    logic [LANES-1:0]                   r_out_sat;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = reset_n && w_en;

    assign w_t_prod  = r_p_data[MUL_STAGES-1];
    assign w_t_valid = r_p_valid[MUL_STAGES-1];
    assign w_t_acc   = r_p_acc[MUL_STAGES-1];
    assign w_t_last  = r_p_last[MUL_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACC_WIDTH-1:0] w_a_ext;
            logic [ACC_WIDTH-1:0] w_b_ext;
            logic [ACC_WIDTH:0]   w_p_ext;
            logic [ACC_WIDTH:0]   w_base;
            logic [ACC_WIDTH:0]   w_sum;

            assign w_a_ext = {{(ACC_WIDTH-A_WIDTH){r_in_a[gi*A_WIDTH+A_WIDTH-1]}},
                              r_in_a[gi*A_WIDTH +: A_WIDTH]};

            if (B_SIGNED != 0) begin : g_b_signed
                assign w_b_ext = {{(ACC_WIDTH-B_WIDTH){r_in_b[gi*B_WIDTH+B_WIDTH-1]}},
                                  r_in_b[gi*B_WIDTH +: B_WIDTH]};
            end else begin : g_b_unsigned
                assign w_b_ext = {{(ACC_WIDTH-B_WIDTH){1'b0}},
                                  r_in_b[gi*B_WIDTH +: B_WIDTH]};
            end

            // Low ACC_WIDTH bits of the modular product equal the exact signed product.
            assign w_prod[gi] = w_a_ext * w_b_ext;

            // One guard bit makes overflow of base+P visible without loss.
            assign w_p_ext = {w_t_prod[gi][ACC_WIDTH-1], w_t_prod[gi]};
            assign w_base  = r_group_open ? {r_acc[gi][ACC_WIDTH-1], r_acc[gi]} : '0;
            assign w_sum   = w_base + w_p_ext;
            assign w_ovf[gi] = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
            assign w_sum_sat[gi] = !w_ovf[gi] ? w_sum[ACC_WIDTH-1:0]
                                 : (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
        end
    endgenerate

    // Valid bits of the operand register and product stages, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_valid <= 1'b0;
            r_p_valid  <= '0;
        end else if (w_en) begin
            r_in_valid   <= in_valid;
            r_p_valid[0] <= r_in_valid;
            for (int s = 1; s < MUL_STAGES; s++) begin
                r_p_valid[s] <= r_p_valid[s-1];
            end
        end
    end

    // Operand/product data and beat tags travel with the valid bits.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_in_a      <= in_a;
            r_in_b      <= in_b;
            r_in_acc    <= in_acc;
            r_in_last   <= in_last;
            r_p_data[0] <= w_prod;
            r_p_acc[0]  <= r_in_acc;
            r_p_last[0] <= r_in_last;
            for (int s = 1; s < MUL_STAGES; s++) begin
                r_p_data[s] <= r_p_data[s-1];
                r_p_acc[s]  <= r_p_acc[s-1];
                r_p_last[s] <= r_p_last[s-1];
            end
        end
    end

    // Accumulate stage: update group state and load the output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_sat        <= '0;
            r_group_open <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sat    <= '0;
        end else if (w_en) begin
            r_out_valid <= w_t_valid && (!w_t_acc || w_t_last);
            if (w_t_valid) begin
                if (!w_t_acc) begin
                    // A lone product always fits, so saturating it is the identity.
                    r_out_data <= w_t_prod;
                    r_out_sat  <= '0;
                end else if (!w_t_last) begin
                    r_acc        <= w_sum_sat;
                    r_sat        <= r_sat | w_ovf;
                    r_group_open <= 1'b1;
                end else begin
                    r_out_data   <= w_sum_sat;
                    r_out_sat    <= r_sat | w_ovf;
                    r_acc        <= '0;
                    r_sat        <= '0;
                    r_group_open <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule
